// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped write-through cache controller over external tag/data BRAMs.
// Build option: define CACHE_STATS_EN to get saturating hit/miss counters on hit_cnt_o/miss_cnt_o.
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req_valid_i/req_ready_o/req_we_i   CPU request handshake, one request in flight
//   req_addr_i/req_wdata_i             CPU word address (tag|index) and write data
//   rsp_valid_o/rsp_rdata_o            one-cycle response pulse, read data (0 for writes)
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_ack_i/mem_rdata_i  backing-memory port
//   tag_*/data_*                       single-port BRAM interfaces, 1-cycle read latency
//   hit_cnt_o/miss_cnt_o               statistics counters (0 when stats are disabled)
module dm_cache_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 5,
    localparam int TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [DATA_WIDTH-1:0]  req_wdata_i,
    output logic                   rsp_valid_o,
    output logic [DATA_WIDTH-1:0]  rsp_rdata_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    output logic [DATA_WIDTH-1:0]  mem_wdata_o,
    input  logic                   mem_ack_i,
    input  logic [DATA_WIDTH-1:0]  mem_rdata_i,
    output logic                   tag_en_o,
    output logic                   tag_we_o,
    output logic [INDEX_WIDTH-1:0] tag_addr_o,
    output logic [TAG_WIDTH-1:0]   tag_wdata_o,
    input  logic [TAG_WIDTH-1:0]   tag_rdata_i,
    output logic                   data_en_o,
    output logic                   data_we_o,
    output logic [INDEX_WIDTH-1:0] data_addr_o,
    output logic [DATA_WIDTH-1:0]  data_wdata_o,
    input  logic [DATA_WIDTH-1:0]  data_rdata_i,
    output logic [31:0]            hit_cnt_o,
    output logic [31:0]            miss_cnt_o
);
    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, REFILL, MEM_WR} state_e;
    state_e                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic                      we_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [2**INDEX_WIDTH-1:0] valid_q, valid_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [INDEX_WIDTH-1:0]    idx_q;
    logic [TAG_WIDTH-1:0]      tag_q;
    logic                      accept, hit, lookup;
    assign idx_q       = addr_q[INDEX_WIDTH-1:0];
    assign tag_q       = addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
    assign req_ready_o = state_q == IDLE;
    assign accept      = req_valid_i && req_ready_o;
    assign lookup      = state_q == LOOKUP;
    assign hit         = valid_q[idx_q] && tag_rdata_i == tag_q;
    // BRAM address follows the live request while idle so the read is issued in the accept cycle.
    assign tag_addr_o   = req_ready_o ? req_addr_i[INDEX_WIDTH-1:0] : idx_q;
    assign data_addr_o  = tag_addr_o;
    assign tag_wdata_o  = tag_q;
    // During REFILL the captured memory word already sits in rsp_rdata_q.
    assign data_wdata_o = state_q == REFILL ? rsp_rdata_q : wdata_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        tag_en_o    = 1'b0;
        tag_we_o    = 1'b0;
        data_en_o   = 1'b0;
        data_we_o   = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        case (state_q)
            IDLE: begin
                tag_en_o  = accept;
                data_en_o = accept;
                state_d   = accept ? LOOKUP : IDLE;
            end
            LOOKUP: begin
                data_en_o   = we_q && hit;
                data_we_o   = we_q && hit;
                rsp_valid_d = !we_q && hit;
                rsp_rdata_d = !we_q && hit ? data_rdata_i : rsp_rdata_q;
                state_d     = we_q ? MEM_WR : (hit ? IDLE : MEM_RD);
            end
            MEM_RD: begin
                mem_req_o   = 1'b1;
                rsp_valid_d = mem_ack_i;
                rsp_rdata_d = mem_ack_i ? mem_rdata_i : rsp_rdata_q;
                state_d     = mem_ack_i ? REFILL : MEM_RD;
            end
            REFILL: begin
                tag_en_o       = 1'b1;
                tag_we_o       = 1'b1;
                data_en_o      = 1'b1;
                data_we_o      = 1'b1;
                valid_d[idx_q] = 1'b1;
                state_d        = IDLE;
            end
            MEM_WR: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                rsp_valid_d = mem_ack_i;
                rsp_rdata_d = mem_ack_i ? '0 : rsp_rdata_q;
                state_d     = mem_ack_i ? IDLE : MEM_WR;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (accept) begin
                addr_q  <= req_addr_i;
                we_q    <= req_we_i;
                wdata_q <= req_wdata_i;
            end
        end
    end
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (lookup) begin
            if (hit && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (!hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end
    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    logic unused_lookup;
    assign unused_lookup = lookup;
    assign hit_cnt_o     = '0;
    assign miss_cnt_o    = '0;
`endif
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed self-checking bench with a transaction-level cache model.
module tb_dm_cache_ctrl;
    localparam int DW = 32, AW = 32, IW = 5, TW = AW - IW;
    logic          clk = 1'b0, rst_n = 1'b0;
    logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          mem_req, mem_we, mem_ack = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata = '0;
    logic          tag_en, tag_we, data_en, data_we;
    logic [IW-1:0] tag_addr, data_addr;
    logic [TW-1:0] tag_wdata, tag_rdata;
    logic [DW-1:0] data_wdata, data_rdata;
    logic [31:0]   hit_cnt, miss_cnt;

    dm_cache_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
        .tag_en_o(tag_en), .tag_we_o(tag_we), .tag_addr_o(tag_addr),
        .tag_wdata_o(tag_wdata), .tag_rdata_i(tag_rdata),
        .data_en_o(data_en), .data_we_o(data_we), .data_addr_o(data_addr),
        .data_wdata_o(data_wdata), .data_rdata_i(data_rdata),
        .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
    );

    always #5 clk = ~clk;

    logic [TW-1:0] tag_mem [32];
    logic [DW-1:0] data_mem [32];
    always @(posedge clk) begin
        if (tag_en) begin
            if (tag_we) tag_mem[tag_addr] <= tag_wdata;
            tag_rdata <= tag_mem[tag_addr];
        end
        if (data_en) begin
            if (data_we) data_mem[data_addr] <= data_wdata;
            data_rdata <= data_mem[data_addr];
        end
    end

    bit            m_valid [32];
    logic [TW-1:0] m_tag [32];
    logic [DW-1:0] m_data [32];
    int            m_hits = 0, m_miss = 0;

    bit            chk_en = 1'b0;
    bit            exp_ready, exp_rv, exp_mreq, exp_mwe, exp_ten, exp_twe, exp_dwe;
    logic [31:0]   exp_rdata, exp_maddr, exp_mwdata, exp_dwdata;
    logic [IW-1:0] exp_idx;
    logic [TW-1:0] exp_tag;
    int            checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv) chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("mem_req", 32'(mem_req), 32'(exp_mreq));
            if (exp_mreq) begin
                chk("mem_we", 32'(mem_we), 32'(exp_mwe));
                chk("mem_addr", mem_addr, exp_maddr);
                if (exp_mwe) chk("mem_wdata", mem_wdata, exp_mwdata);
            end
            chk("tag_en", 32'(tag_en), 32'(exp_ten));
            chk("tag_we", 32'(tag_we), 32'(exp_twe));
            chk("data_we", 32'(data_we), 32'(exp_dwe));
            if (exp_ten) chk("tag_addr", 32'(tag_addr), 32'(exp_idx));
            if (exp_twe) chk("tag_wdata", 32'(tag_wdata), 32'(exp_tag));
            if (exp_dwe) begin
                chk("data_addr", 32'(data_addr), 32'(exp_idx));
                chk("data_wdata", data_wdata, exp_dwdata);
            end
        end
    end

    task automatic chk_stats();
`ifdef CACHE_STATS_EN
        chk("hit_cnt", hit_cnt, 32'(m_hits));
        chk("miss_cnt", miss_cnt, 32'(m_miss));
`else
        chk("hit_cnt", hit_cnt, 32'd0);
        chk("miss_cnt", miss_cnt, 32'd0);
`endif
    endtask

    // One request: d = number of cycles mem_req is held (ack in its last cycle).
    task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input int d, input logic [31:0] md);
        int            idx, rc, last;
        logic [TW-1:0] tg;
        bit            hit, rmiss, usemem;
        logic [31:0]   rd;
        idx    = int'(addr[IW-1:0]);
        tg     = addr[AW-1:IW];
        hit    = m_valid[idx] && m_tag[idx] == tg;
        rmiss  = !we && !hit;
        usemem = we || !hit;
        rc     = usemem ? 2 + d : 2;
        last   = rc + (rmiss ? 1 : 0);
        rd     = we ? 32'd0 : (hit ? m_data[idx] : md);
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            req_valid  = c == 0;
            req_we     = we;
            req_addr   = addr;
            req_wdata  = wd;
            mem_ack    = usemem && c == 1 + d;
            mem_rdata  = md;
            exp_ready  = c == 0 || c >= last;
            exp_rv     = c == rc;
            exp_rdata  = rd;
            exp_mreq   = usemem && c >= 2 && c <= 1 + d;
            exp_mwe    = we;
            exp_maddr  = addr;
            exp_mwdata = wd;
            exp_ten    = c == 0 || (rmiss && c == rc);
            exp_twe    = rmiss && c == rc;
            exp_idx    = IW'(idx);
            exp_tag    = tg;
            exp_dwe    = (we && hit && c == 1) || (rmiss && c == rc);
            exp_dwdata = we ? wd : md;
            chk_en     = 1'b1;
        end
        if (hit) m_hits++;
        else m_miss++;
        if (we && hit) m_data[idx] = wd;
        if (rmiss) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_data[idx]  = md;
        end
        chk_stats();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_bram_en", 32'({tag_en, tag_we, data_en, data_we}), 32'd0);
        chk_stats();
        rst_n = 1'b1;
        txn(1'b0, 32'h40, 32'h0, 3, 32'hDEAD_BEEF);
        chk("first_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("refill_tag", 32'(tag_mem[0]), 32'h2);
        chk("refill_data", data_mem[0], 32'hDEAD_BEEF);
        txn(1'b0, 32'h40, 32'h0, 3, 32'h0BAD_0BAD);
        chk("reread_rdata", rsp_rdata, 32'hDEAD_BEEF);
`ifdef CACHE_STATS_EN
        chk("hit_cnt_lit", hit_cnt, 32'd1);
`endif
        txn(1'b1, 32'h40, 32'h1234_5678, 2, 32'h0);
        chk("write_rdata_zero", rsp_rdata, 32'd0);
        txn(1'b0, 32'h40, 32'h0, 2, 32'h0BAD_0BAD);
        chk("hit_after_write", rsp_rdata, 32'h1234_5678);
        txn(1'b1, 32'h60, 32'hAAAA_5555, 1, 32'h0);
        chk("no_alloc_tag", 32'(tag_mem[0]), 32'h2);
        txn(1'b0, 32'h40, 32'h0, 2, 32'h0BAD_0BAD);
        txn(1'b0, 32'h60, 32'h0, 1, 32'hCAFE_F00D);
        chk("evict_tag", 32'(tag_mem[0]), 32'h3);
        txn(1'b0, 32'h40, 32'h0, 2, 32'h1234_5678);
        txn(1'b0, 32'h3F, 32'h0, 1, 32'h5555_AAAA);
        txn(1'b0, 32'h3F, 32'h0, 1, 32'h0BAD_0BAD);
        chk("idx31_hit", rsp_rdata, 32'h5555_AAAA);
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h81;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mem_req_pre_rst", 32'(mem_req), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mem_req_async_drop", 32'(mem_req), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
        m_valid = '{default: 1'b0};
        m_hits  = 0;
        m_miss  = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_stats();
        @(posedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBADD_CAFE;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_ack_rsp", 32'(rsp_valid), 32'd0);
            chk("late_ack_mem_req", 32'(mem_req), 32'd0);
            @(posedge clk);
            #1;
        end
        txn(1'b0, 32'h40, 32'h0, 2, 32'h1234_5678);
        txn(1'b0, 32'h40, 32'h0, 1, 32'h0BAD_0BAD);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Direct-mapped, write-through cache controller. It sits directly upstream of two single-port BRAM instances (tag array and data array): it drives their addr/en/we/data and consumes their registered, 1-cycle-latency read data.
- Valid bits are held in an internal flop vector because the BRAMs have no reset.
- One CPU request is in flight at a time; misses and writes go to a backing memory through a req/ack port.

Parameters:
- DATA_WIDTH, 32, width of a word, CPU data and memory data.
- ADDR_WIDTH, 32, CPU word-address width.
- INDEX_WIDTH, 5, set index width. Equals the BRAM ADDR_WIDTH; 2**INDEX_WIDTH lines, one word per line.
- Derived, not overridable: TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH.

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  CPU request valid.
- req_ready_o  out  1  controller can accept a request.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_WIDTH  word address; index = [INDEX_WIDTH-1:0], tag = upper bits.
- req_wdata_i  in  DATA_WIDTH  write data.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes.
- mem_req_o  out  1  backing-memory request.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_ack_i  in  1  one-cycle memory acknowledge.
- mem_rdata_i  in  DATA_WIDTH  memory read data, valid with ack.
- tag_en_o, tag_we_o  out  1  tag BRAM enable / write enable.
- tag_addr_o  out  INDEX_WIDTH  tag BRAM address.
- tag_wdata_o  out  TAG_WIDTH  tag write data.
- tag_rdata_i  in  TAG_WIDTH  tag BRAM read data, one cycle after en.
- data_en_o, data_we_o  out  1  data BRAM enable / write enable.
- data_addr_o  out  INDEX_WIDTH  data BRAM address.
- data_wdata_o  out  DATA_WIDTH  data write data.
- data_rdata_i  in  DATA_WIDTH  data BRAM read data, one cycle after en.
- hit_cnt_o, miss_cnt_o  out  32  statistics counters (see Optional Feature).

Behaviour:
- Reset values: FSM = IDLE; valid vector all 0; req_ready_o = 1; rsp_valid_o = 0; rsp_rdata_o = 0; mem_req_o = 0; all BRAM en/we = 0; counters = 0.
- Request capture:
  - req_ready_o = 1 only in IDLE.
  - On req_valid_i && req_ready_o, the request is latched.
  - In that same cycle, tag_en_o = data_en_o = 1 (we = 0) and both BRAM addresses = req_addr_i index, driven combinationally.
- States: IDLE, LOOKUP, MEM_RD, REFILL, MEM_WR.
- IDLE -> LOOKUP on accept.
- LOOKUP: hit = valid[idx] && tag_rdata_i == latched tag.
  - Read hit: register rsp_valid_o = 1 and rsp_rdata_o = data_rdata_i -> IDLE. Response in cycle 2, where acceptance is cycle 0.
  - Read miss -> MEM_RD.
  - Write hit: drive data_en_o = data_we_o = 1, data_wdata_o = wdata -> MEM_WR.
  - Write miss -> MEM_WR. No allocate; BRAMs untouched.
- MEM_RD:
  - mem_req_o = 1, mem_we_o = 0, mem_addr_o = latched address.
  - Hold all of these stable until mem_ack_i; an ack in the first cycle of req is legal.
  - On ack: capture mem_rdata_i -> REFILL.
- REFILL:
  - Write tag BRAM (tag) and data BRAM (captured data) at idx; set valid[idx].
  - rsp_valid_o = 1 with captured data -> IDLE. Miss response arrives the cycle after ack.
- MEM_WR:
  - mem_req_o = 1, mem_we_o = 1, address and wdata held stable until ack.
  - On ack: rsp_valid_o = 1, rsp_rdata_o = 0 -> IDLE.
- rsp_valid_o is high exactly one cycle per request. rsp_rdata_o holds its value until the next response.
- mem_ack_i is ignored outside MEM_RD/MEM_WR.
- Reset asserted mid-operation:
  - Immediate return to reset values; mem_req_o drops asynchronously; no response is issued.
  - A late ack after reset release is ignored.
- Index aliasing: different tag, same idx -> miss; the refill overwrites the line.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - hit_cnt_o increments on each LOOKUP hit (read or write).
  - miss_cnt_o increments on each LOOKUP miss.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist. The port list is unchanged.

Test Plan:
- Reset, then read addr 0x0000_0040 with mem_rdata 0xDEAD_BEEF and ack 3 cycles after req -> mem_req_o held 3 cycles; REFILL writes idx 0, tag 0x2; rsp_rdata 0xDEAD_BEEF one cycle after ack.
- Re-read 0x0000_0040 -> no mem_req_o; rsp_valid_o in cycle 2 after accept with 0xDEAD_BEEF; hit_cnt_o = 1 with CACHE_STATS_EN.
- Write 0x1234_5678 to 0x0000_0040 (hit) -> data BRAM written in LOOKUP; mem write with same addr/data; then read returns 0x1234_5678 without a memory read.
- Write to 0x0000_0060 (miss, idx 0, tag 0x3) -> memory write only; next read of 0x0000_0040 still hits.
- Read 0x0000_0060 after the above -> miss, refill evicts idx 0; subsequent read of 0x0000_0040 misses.
- Assert rst_ni low during MEM_RD -> mem_req_o = 0 immediately; all valid bits cleared; ack arriving after release produces no rsp_valid_o; next read of 0x0000_0040 misses.
